// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/execute sequencer: FSM states, datapath widths, reset values.
package cpu_pkg;

  localparam int PC_W  = 8;
  localparam int IR_W  = 8;
  localparam int CNT_W = 16;

  localparam logic [PC_W-1:0] PC_RESET = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Natural binary add, so 0xFF rolls over to 0x00.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: jump load beats increment; increment wraps modulo 2**PC_W.
module pc_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_ld,
  input  logic            i_inc,
  input  logic [PC_W-1:0] i_d,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  // PC state update with load-over-increment priority
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= PC_RESET;
    end else if (i_ld) begin
      r_pc <= i_d;
    end else if (i_inc) begin
      r_pc <= pc_inc(r_pc);
    end else begin
      r_pc <= r_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_seq.sv
// Two-phase instruction fetch/execute sequencer with halt/resume, single-step and a
// saturating retired-instruction counter.
module fetch_seq
  import cpu_pkg::*;
#(
  parameter int ICNT_W = CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step_mode,
  input  logic              sm_en,
  input  logic              ir_ld,
  input  logic              pc_in,
  input  logic              pc_ld,
  input  logic [IR_W-1:0]   d_bus,
  output logic              sm,
  output logic [IR_W-1:0]   ir,
  output logic [PC_W-1:0]   pc_addr,
  output logic              halted,
  output logic [ICNT_W-1:0] icount
);

  state_t            r_state;
  logic              r_sm;
  logic              r_halted;
  logic [IR_W-1:0]   r_ir;
  logic [ICNT_W-1:0] r_icount;
  logic              w_pc_ld;
  logic              w_pc_inc;

  // Qualify PC controls by phase: increment in FETCH/EXEC, jump in EXEC only
  always_comb begin
    w_pc_ld  = 1'b0;
    w_pc_inc = 1'b0;
    case (r_state)
      FETCH: begin
        w_pc_ld  = 1'b0;
        w_pc_inc = pc_in;
      end
      EXEC: begin
        w_pc_ld  = pc_ld;
        w_pc_inc = pc_in;
      end
      default: begin
        w_pc_ld  = 1'b0;
        w_pc_inc = 1'b0;
      end
    endcase
  end

  pc_reg u_pc_reg (
    .clk   (clk),
    .rst   (rst),
    .i_ld  (w_pc_ld),
    .i_inc (w_pc_inc),
    .i_d   (d_bus),
    .o_pc  (pc_addr)
  );

  // Sequencer FSM; sm/halted are registered alongside the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ir     <= '0;
      r_sm     <= 1'b0;
      r_halted <= 1'b0;
      r_icount <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= FETCH;
          end
        end
        FETCH: begin
          if (ir_ld) begin
            r_ir <= d_bus;
          end
          r_state <= EXEC;
          r_sm    <= 1'b1;
        end
        EXEC: begin
          r_sm <= 1'b0;
          if (!sm_en) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else begin
            // Retired count sticks at all-ones instead of wrapping
            if (r_icount != '1) begin
              r_icount <= r_icount + ICNT_W'(1);
            end
            r_state <= step_mode ? IDLE : FETCH;
          end
        end
        HALT: begin
          if (start) begin
            r_state  <= FETCH;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_sm     <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign sm     = r_sm;
  assign halted = r_halted;
  assign ir     = r_ir;
  assign icount = r_icount;

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 The block SHALL use one clock and one reset; the reset is synchronous and active-high.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port start, input, 1 bit: leaves IDLE or HALT and begins or resumes fetching.
REQ-005 Port step_mode, input, 1 bit: 1 means return to IDLE after each EXEC.
REQ-006 Port sm_en, input, 1 bit: 0 during EXEC means halt instruction; 1 means continue.
REQ-007 Port ir_ld, input, 1 bit: load IR from d_bus; honoured in FETCH only.
REQ-008 Port pc_in, input, 1 bit: increment PC.
REQ-009 Port pc_ld, input, 1 bit: load PC from d_bus as jump target; honoured in EXEC only.
REQ-010 Port d_bus, input, 8 bits: RAM read data.
REQ-011 Port sm, output, 1 bit: cycle phase; 0 is fetch, 1 is execute.
REQ-012 Port ir, output, 8 bits: instruction register.
REQ-013 Port pc_addr, output, 8 bits: current PC, used as RAM address.
REQ-014 Port halted, output, 1 bit: 1 while in HALT.
REQ-015 Port icount, output, 16 bits: count of retired instructions.

Function
REQ-016 The FSM SHALL have four states: IDLE, FETCH, EXEC and HALT.
REQ-017 All outputs SHALL be registered or decoded from state only; there are no combinational paths from inputs to outputs.
REQ-018 sm SHALL be 1 only in EXEC; halted SHALL be 1 only in HALT.
REQ-019 IDLE: PC and IR hold; start=1 SHALL go to FETCH next cycle, otherwise stay in IDLE.
REQ-020 FETCH, in one cycle:
- ir_ld=1 SHALL load IR with d_bus.
- pc_in=1 SHALL increment PC.
- pc_ld and sm_en are ignored.
- The next state SHALL always be EXEC.
REQ-021 EXEC PC update: pc_ld=1 SHALL load PC with d_bus; else pc_in=1 SHALL increment PC; else PC holds.
REQ-022 pc_ld SHALL take priority over pc_in when both are 1 in EXEC.
REQ-023 ir_ld SHALL be ignored in EXEC.
REQ-024 EXEC next state: sm_en=0 SHALL go to HALT, with the PC update of REQ-021 still applied.
REQ-025 EXEC next state when sm_en=1: step_mode=1 SHALL go to IDLE; else FETCH.
REQ-026 icount SHALL increment on every EXEC cycle with sm_en=1 and SHALL saturate at 0xFFFF with no wrap.
REQ-027 An EXEC cycle that halts SHALL NOT increment icount.
REQ-028 HALT: PC, IR and icount hold; ir_ld, pc_in and pc_ld are ignored.
REQ-029 HALT: start=1 SHALL go to FETCH with PC preserved (resume).
REQ-030 PC increment SHALL wrap modulo 256 (0xFF -> 0x00).
REQ-031 start SHALL be ignored in FETCH and EXEC.
REQ-032 Each instruction SHALL take exactly 2 cycles (FETCH then EXEC) when step_mode=0.

Reset
REQ-033 rst=1 at a clock edge SHALL force, at that edge:
- state = IDLE
- pc_addr = 0x00
- ir = 0x00
- sm = 0
- halted = 0
- icount = 0x0000
REQ-034 Reset SHALL override all other inputs in any state, including mid-EXEC and in HALT.
REQ-035 The first non-reset edge SHALL evaluate from IDLE.

Structure
REQ-036 Shared package cpu_pkg SHALL hold:
- the state enumeration (IDLE, FETCH, EXEC, HALT)
- PC_W=8, IR_W=8, CNT_W=16
- PC_RESET=0x00
REQ-037 One sub-module, pc_reg, SHALL implement the PC register with load/increment priority and wrap; everything else stays in fetch_seq.

Verification
REQ-038 Basic cycle: rst, then start=1 for 1 cycle, ir_ld=1, pc_in=1 in FETCH, d_bus=0x3A -> next cycle ir=0x3A, pc_addr=0x01, sm=1.
REQ-039 Jump: EXEC with pc_ld=1, pc_in=1, d_bus=0xC0 -> pc_addr=0xC0, state FETCH, icount +1.
REQ-040 Wrap and saturation:
- PC=0xFF with pc_in=1 -> pc_addr=0x00.
- icount preset to 0xFFFF by 65535 instructions -> one more instruction leaves icount at 0xFFFF.
REQ-041 Halt and resume:
- EXEC with sm_en=0 -> halted=1, icount unchanged.
- ir_ld/pc_in pulses in HALT -> no change.
- start=1 -> FETCH with pc_addr unchanged.
REQ-042 Step mode and mid-operation reset:
- step_mode=1 -> IDLE after each EXEC; no FETCH without start.
- rst asserted in EXEC with pc_ld=1 -> pc_addr=0x00, ir=0x00, sm=0, state IDLE.
